div_sched: RTL and testbench

Round-robin scheduler and sequencer that shares one N-bit restoring shift-subtract divider between two requesters. It arbitrates requests, latches the winner's operands, runs the divider for exactly N iterations, and returns quotient and remainder tagged with the owner's ID. It sits between client logic and the divider datapath, which it contains internally. It replaces per-client dividers and adds reset, a defined start handshake and divide-by-zero handling.

---
 rtl/div_sched.sv | 184 ++++++++++++++++++
 tb/tb_div_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sched.sv
// div_sched: round-robin arbiter for two clients sharing one restoring
// shift-subtract divider. It grants one client per operation, runs N
// iterations, and returns the quotient and remainder tagged with the owner.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | waiting for a request; grants combinationally, latches operands
//   S_RUN  | one divide iteration per cycle, N cycles in total
//   S_DONE | result registers valid, done pulse high for this one cycle
module div_sched #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [N-1:0] dividend0,
  input  logic [N-1:0] dividend1,
  input  logic [N-1:0] divisor0,
  input  logic [N-1:0] divisor1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         dz
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  // The partial remainder A is N+1 bits wide during the compare, but after
  // every restore step A < divisor < 2^N, so its top bit is always zero and
  // only the low N bits need to be stored.
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          done_id_q, done_id_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dz_q, dz_d;

  logic          pick0, pick1;
  logic          sel_k;
  logic [N-1:0]  sel_dvd, sel_dvs;
  logic [N:0]    shifted;
  logic [N:0]    diff;
  logic          ge;
  logic [N-1:0]  nxt_acc;
  logic [N-1:0]  nxt_q;

  // Arbitration: a lone request wins; on contention the client not served last wins.
  always_comb begin
    pick0 = req0 & (~req1 | last_q);
    pick1 = req1 & (~req0 | ~last_q);
    gnt0  = ~rst & (state_q == S_IDLE) & pick0;
    gnt1  = ~rst & (state_q == S_IDLE) & pick1;
    sel_k   = gnt1;
    sel_dvd = gnt1 ? dividend1 : dividend0;
    sel_dvs = gnt1 ? divisor1  : divisor0;
  end

  // One restoring shift-subtract step on the current {A,Q}.
  always_comb begin
    shifted = {acc_q, q_q[N-1]};
    diff    = shifted - {1'b0, dvs_q};
    ge      = (shifted >= {1'b0, dvs_q});
    nxt_acc = ge ? diff[N-1:0] : shifted[N-1:0];
    nxt_q   = {q_q[N-2:0], ge};
  end

  // Next-state and next-result computation for the sequencer.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    acc_d     = acc_q;
    q_d       = q_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dz_d      = dz_q;
    case (state_q)
      S_IDLE: begin
        if (gnt0 | gnt1) begin
          last_d  = sel_k;
          owner_d = sel_k;
          if (sel_dvs == '0) begin
            // Divide-by-zero skips the datapath and reports straight away.
            quo_d     = '1;
            rem_d     = sel_dvd;
            dz_d      = 1'b1;
            done_id_d = sel_k;
            done_d    = 1'b1;
            state_d   = S_DONE;
          end else begin
            acc_d   = '0;
            q_d     = sel_dvd;
            dvs_d   = sel_dvs;
            cnt_d   = '0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_d = nxt_acc;
        q_d   = nxt_q;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          quo_d     = nxt_q;
          rem_d     = nxt_acc;
          dz_d      = 1'b0;
          done_id_d = owner_q;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers; synchronous reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      acc_q     <= '0;
      q_q       <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dz_q      <= dz_d;
    end
  end

  // Output drive from registered state.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = done_q;
    done_id   = done_id_q;
    quotient  = quo_q;
    remainder = rem_q;
    dz        = dz_q;
  end

endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: directed table, multi-cycle corner
// sequences, and a randomized sweep against an integer-divide model.
module tb_div_sched;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         req0, req1;
  logic [N-1:0] dividend0, dividend1, divisor0, divisor1;
  logic         gnt0, gnt1, busy, done, done_id, dz;
  logic [N-1:0] quotient, remainder;

  int errors;
  int checks;
  bit last_m;

  div_sched #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .dividend0 (dividend0),
    .dividend1 (dividend1),
    .divisor0  (divisor0),
    .divisor1  (divisor1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         c;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] eq;
    logic [7:0] er;
    bit         edz;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain unsigned integer divide, all-ones quotient on zero divisor.
  function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output bit z);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    if (ib == 0) begin
      q = 8'hFF;
      r = a;
      z = 1'b1;
    end else begin
      q = 8'(ia / ib);
      r = 8'(ia % ib);
      z = 1'b0;
    end
  endfunction

  // Issues one request (or a contended pair) from an idle DUT and checks the
  // grant, latency, result holding and the result against the model.
  task automatic run_op(input bit r0, input bit r1,
                        input logic [7:0] a0, input logic [7:0] b0,
                        input logic [7:0] a1, input logic [7:0] b1,
                        output logic [7:0] oq, output logic [7:0] orr,
                        output logic odz, output logic oid);
    bit w;
    logic [7:0] eq, er;
    bit edz;
    logic [7:0] hq, hr;
    logic hdz, hid;
    int lat, elat;
    bit stable, extra_gnt;
    w = (r0 && r1) ? ~last_m : r1;
    req0 = r0; req1 = r1;
    dividend0 = a0; divisor0 = b0;
    dividend1 = a1; divisor1 = b1;
    @(negedge clk);
    chk("gnt0", gnt0, !w);
    chk("gnt1", gnt1, w);
    hq = quotient; hr = remainder; hdz = dz; hid = done_id;
    last_m = w;
    if (w) ref_div(a1, b1, eq, er, edz);
    else   ref_div(a0, b0, eq, er, edz);
    elat = edz ? 1 : N + 1;
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    dividend0 = 8'($urandom); divisor0 = 8'($urandom);
    dividend1 = 8'($urandom); divisor1 = 8'($urandom);
    lat = 0; stable = 1'b1; extra_gnt = 1'b0;
    while (lat < N + 4) begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (quotient !== hq || remainder !== hr || dz !== hdz || done_id !== hid) stable = 1'b0;
      if (gnt0 || gnt1) extra_gnt = 1'b1;
    end
    chk("latency", lat, elat);
    chk("result_held", stable, 1);
    chk("no_gnt_while_busy", extra_gnt, 0);
    chk("busy_at_done", busy, 1);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("dz", dz, edz);
    chk("done_id", done_id, w);
    oq = quotient; orr = remainder; odz = dz; oid = done_id;
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t vt[10];
    logic [7:0] oq, orr;
    logic odz, oid;
    bit seen;
    int gc[$];
    bit gk[$];
    bit own[$];
    int dbl, ndone;
    bit k;

    vt[0] = '{1'b0, 8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
    vt[1] = '{1'b1, 8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    vt[2] = '{1'b1, 8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
    vt[3] = '{1'b0, 8'd13,  8'd0,   8'd255, 8'd13,  1'b1};
    vt[4] = '{1'b1, 8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
    vt[5] = '{1'b0, 8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
    vt[6] = '{1'b1, 8'd254, 8'd255, 8'd0,   8'd254, 1'b0};
    vt[7] = '{1'b0, 8'd200, 8'd16,  8'd12,  8'd8,   1'b0};
    vt[8] = '{1'b1, 8'd1,   8'd0,   8'd255, 8'd1,   1'b1};
    vt[9] = '{1'b0, 8'd128, 8'd3,   8'd42,  8'd2,   1'b0};

    errors = 0; checks = 0;
    rst = 1'b1;
    req0 = 1'b1; req1 = 1'b0;
    dividend0 = 8'd100; divisor0 = 8'd7;
    dividend1 = 8'd0;   divisor1 = 8'd0;

    // Reset overrides a pending request.
    @(negedge clk);
    chk("gnt0_in_reset", gnt0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    req0 = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dz", dz, 0);
    chk("rst_gnt1", gnt1, 0);
    @(posedge clk); #1;
    last_m = 1'b1;

    // Directed table, back to back to exercise N+2 throughput.
    for (int i = 0; i < 10; i++) begin
      run_op(!vt[i].c, vt[i].c, vt[i].a, vt[i].b, vt[i].a, vt[i].b, oq, orr, odz, oid);
      chk("tbl_quotient", oq, vt[i].eq);
      chk("tbl_remainder", orr, vt[i].er);
      chk("tbl_dz", odz, vt[i].edz);
      chk("tbl_done_id", oid, vt[i].c);
    end

    // Reset four cycles into a RUN aborts with no done pulse.
    req0 = 1'b1; dividend0 = 8'd100; divisor0 = 8'd7;
    @(negedge clk);
    chk("mr_gnt0", gnt0, 1);
    @(posedge clk); #1;
    req0 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_quotient", quotient, 0);
    chk("mr_remainder", remainder, 0);
    chk("mr_dz", dz, 0);
    chk("mr_done_id", done_id, 0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("mr_no_done", seen, 0);
    @(posedge clk); #1;
    last_m = 1'b1;

    // Both clients held from reset: grants alternate 0,1,0,1 every N+2 cycles.
    req0 = 1'b1; dividend0 = 8'd200; divisor0 = 8'd3;
    req1 = 1'b1; dividend1 = 8'd77;  divisor1 = 8'd10;
    dbl = 0; ndone = 0;
    for (int cyc = 1; cyc <= 4 * (N + 2); cyc++) begin
      @(negedge clk);
      if (gnt0 && gnt1) dbl++;
      if (gnt0 || gnt1) begin
        gc.push_back(cyc);
        gk.push_back(gnt1);
        own.push_back(gnt1);
      end
      if (done) begin
        ndone++;
        if (own.size() == 0) chk("ct_done_without_grant", 1, 0);
        else begin
          k = own.pop_front();
          chk("ct_done_id", done_id, k);
          chk("ct_quotient", quotient, k ? 8'd7 : 8'd66);
          chk("ct_remainder", remainder, k ? 8'd7 : 8'd2);
        end
      end
      @(posedge clk); #1;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("ct_double_grant", dbl, 0);
    chk("ct_grant_count", gc.size(), 4);
    chk("ct_done_count", ndone, 4);
    for (int i = 0; i < gc.size(); i++) begin
      chk("ct_grant_order", gk[i], i % 2);
      if (i > 0) chk("ct_grant_spacing", gc[i] - gc[i-1], N + 2);
    end
    last_m = 1'b1;
    @(posedge clk); #1;

    // Randomized sweep with random idle gaps, contention and divisor zero.
    for (int i = 0; i < 1000; i++) begin
      int gap, mode;
      logic [7:0] a0, b0, a1, b1;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        dividend0 = 8'($urandom); divisor0 = 8'($urandom);
        @(posedge clk); #1;
      end
      mode = $urandom_range(0, 3);
      a0 = 8'($urandom); a1 = 8'($urandom);
      b0 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      b1 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      run_op(mode != 1, mode != 0, a0, b0, a1, b1, oq, orr, odz, oid);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
